// File: rtl/lcd_reader_if.sv
// lcd_reader_if
//   Host-side handshake bundle for the LCD read engine.
//   master : requester (write controller / sequencer / testbench)
//   slave  : lcd_reader
//   Signals:
//     req, rs_sel     read request and register select (0=BF/AC, 1=data)
//     poll_req        start a busy-flag poll (only honoured when the poll feature is built)
//     ready           engine idle, req will be accepted
//     valid           one-cycle pulse, rdata updated
//     rdata, bf, ac   last byte read, and BF/AC from the last RS=0 read
//     poll_done       one-cycle pulse, poll ended with BF=0
//     poll_tmo        one-cycle pulse, poll ended after POLL_MAX busy reads
interface lcd_reader_if;
  logic       req;
  logic       rs_sel;
  logic       poll_req;
  logic       ready;
  logic       valid;
  logic [7:0] rdata;
  logic       bf;
  logic [6:0] ac;
  logic       poll_done;
  logic       poll_tmo;

  modport master (
    output req, rs_sel, poll_req,
    input  ready, valid, rdata, bf, ac, poll_done, poll_tmo
  );

  modport slave (
    input  req, rs_sel, poll_req,
    output ready, valid, rdata, bf, ac, poll_done, poll_tmo
  );
endinterface

// File: rtl/lcd_reader.sv
// lcd_reader
//   Read-side engine for an HD44780-class character LCD. Runs one RW=1 bus
//   cycle reading either the busy flag / address counter (RS=0) or DDRAM/CGRAM
//   data (RS=1) with cycle-count timing, and returns the sampled byte.
//   The top level muxes the LCD pins and releases the data tristate while
//   rd_active is high.
//
//   Optional feature macro: LCD_BUSY_POLL_EN
//     When defined, poll_req starts repeated RS=0 reads until BF=0
//     (poll_done) or POLL_MAX busy reads (poll_tmo). When undefined the poll
//     logic is absent and poll_done/poll_tmo are tied low.
//
//   Ports:
//     clk        system clock (50 MHz)
//     rst        synchronous reset, active high
//     bus        lcd_reader_if.slave host handshake (req/rs_sel/ready/valid/...)
//     rd_active  read in progress; top selects these pins and releases LCD_DATA
//     lcd_rs     LCD RS
//     lcd_rw     LCD RW
//     lcd_en     LCD EN
//     lcd_din    LCD_DATA input from the top-level tristate
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   S_IDLE    | pins low, ready=1, waiting for req (or poll_req)
//   S_SETUP   | RS/RW driven, EN low, T_AS cycles address setup
//   S_EN_HI   | EN high for T_PW cycles; lcd_din sampled on the last one
//   S_HOLD    | EN low, RS/RW held T_H cycles; valid on the first one
//   S_RECOVER | bus released, ready=0 for T_REC cycles before the next cycle
module lcd_reader #(
  parameter int T_AS     = 3,
  parameter int T_PW     = 25,
  parameter int T_H      = 2,
  parameter int T_REC    = 25,
  parameter int POLL_MAX = 1000
) (
  input  logic             clk,
  input  logic             rst,
  lcd_reader_if.slave      bus,
  output logic             rd_active,
  output logic             lcd_rs,
  output logic             lcd_rw,
  output logic             lcd_en,
  input  logic [7:0]       lcd_din
);

  localparam int T_MAX_A = (T_AS > T_PW) ? T_AS : T_PW;
  localparam int T_MAX_B = (T_H > T_REC) ? T_H : T_REC;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int CW      = $clog2(T_MAX + 1);

  localparam logic [CW-1:0] LD_AS  = CW'(T_AS - 1);
  localparam logic [CW-1:0] LD_PW  = CW'(T_PW - 1);
  localparam logic [CW-1:0] LD_H   = CW'(T_H - 1);
  localparam logic [CW-1:0] LD_REC = CW'(T_REC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_EN_HI,
    S_HOLD,
    S_RECOVER
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rs_q, rs_d;
  logic          tc;
  logic          sample;
  logic          busy_d;

  logic          valid_q;
  logic          ready_q;
  logic [7:0]    rdata_q;
  logic          bf_q;
  logic [6:0]    ac_q;

  // Poll control; constant when the feature is not built.
  logic          poll_start;
  logic          poll_cont;
  logic          poll_done_d;
  logic          poll_tmo_d;
  logic          poll_done_q;
  logic          poll_tmo_q;

`ifdef LCD_BUSY_POLL_EN
  localparam int PW = (POLL_MAX > 1) ? $clog2(POLL_MAX + 1) : 1;
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX - 1);

  logic          poll_run_q;
  logic [PW-1:0] poll_cnt_q;

  // A poll ends on the first idle read, or on read number POLL_MAX while busy.
  assign poll_done_d = sample & poll_run_q & ~lcd_din[7];
  assign poll_tmo_d  = sample & poll_run_q & lcd_din[7] & (poll_cnt_q == POLL_LAST);
  assign poll_cont   = poll_run_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      poll_run_q <= 1'b0;
      poll_cnt_q <= '0;
    end else if (poll_start) begin
      poll_run_q <= 1'b1;
      poll_cnt_q <= '0;
    end else if (sample && poll_run_q) begin
      if (poll_done_d || poll_tmo_d) begin
        poll_run_q <= 1'b0;
      end else begin
        poll_cnt_q <= poll_cnt_q + PW'(1);
      end
    end
  end
`else
  logic unused_poll_req;
  localparam int unused_poll_max = POLL_MAX;

  assign unused_poll_req = bus.poll_req;
  assign poll_done_d     = 1'b0;
  assign poll_tmo_d      = 1'b0;
  assign poll_cont       = 1'b0;
`endif

  assign tc = (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rs_d       = rs_q;
    sample     = 1'b0;
    poll_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          state_d = S_SETUP;
          cnt_d   = LD_AS;
          rs_d    = bus.rs_sel;
        end
`ifdef LCD_BUSY_POLL_EN
        else if (bus.poll_req) begin
          state_d    = S_SETUP;
          cnt_d      = LD_AS;
          rs_d       = 1'b0;
          poll_start = 1'b1;
        end
`endif
      end
      S_SETUP: begin
        if (tc) begin
          state_d = S_EN_HI;
          cnt_d   = LD_PW;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_EN_HI: begin
        if (tc) begin
          state_d = S_HOLD;
          cnt_d   = LD_H;
          sample  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD: begin
        if (tc) begin
          state_d = S_RECOVER;
          cnt_d   = LD_REC;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_RECOVER: begin
        if (tc) begin
          // A running poll chains straight into the next BF read.
          if (poll_cont) begin
            state_d = S_SETUP;
            cnt_d   = LD_AS;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rs_q    <= rs_d;
    end
  end

  assign busy_d = (state_d == S_SETUP) || (state_d == S_EN_HI) || (state_d == S_HOLD);

  // Pin and status outputs are registered from the next-state decode so they
  // line up with the state register and cannot glitch between states.
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      rdata_q     <= '0;
      bf_q        <= 1'b0;
      ac_q        <= '0;
      rd_active   <= 1'b0;
      lcd_rs      <= 1'b0;
      lcd_rw      <= 1'b0;
      lcd_en      <= 1'b0;
      poll_done_q <= 1'b0;
      poll_tmo_q  <= 1'b0;
    end else begin
      ready_q     <= (state_d == S_IDLE);
      valid_q     <= sample;
      rd_active   <= busy_d;
      lcd_rw      <= busy_d;
      lcd_rs      <= busy_d & rs_d;
      lcd_en      <= (state_d == S_EN_HI);
      poll_done_q <= poll_done_d;
      poll_tmo_q  <= poll_tmo_d;
      if (sample) begin
        rdata_q <= lcd_din;
        if (!rs_q) begin
          bf_q <= lcd_din[7];
          ac_q <= lcd_din[6:0];
        end
      end
    end
  end

  assign bus.ready     = ready_q;
  assign bus.valid     = valid_q;
  assign bus.rdata     = rdata_q;
  assign bus.bf        = bf_q;
  assign bus.ac        = ac_q;
  assign bus.poll_done = poll_done_q;
  assign bus.poll_tmo  = poll_tmo_q;

endmodule
